// File: rtl/reg_hex_scanner.sv
// Purpose: snapshots the core's register view on FRAME_START and streams it out as ASCII hex text, one register per row.
// Latency: first character is valid the cycle after the FRAME_START edge; one character per cycle after that; DONE one cycle after the last transfer.
// Backpressure: CH_VALID/CH_READY handshake. CH_CODE/CH_ROW/CH_COL are registered and hold while CH_READY=0.
//
// Ports:
//   CLK, RST (async active-low)
//   REGS        flattened register view, R1 = [31:0] ... R<NREGS> = top word
//   FRAME_START one-cycle scan request, honoured only when idle
//   CH_VALID/CH_READY/CH_CODE/CH_ROW/CH_COL  character stream to the text writer
//   BUSY        high while a scan is in progress, including the final DONE cycle
//   DONE        one-cycle pulse after the last transfer
// Build option: define REG_SCAN_LABEL_EN to prefix each row with "NN:" (register
// number, two decimal digits, colon); hex digits then occupy cols 3..10.

module reg_hex_scanner #(
    parameter int NREGS = 32,
    parameter bit UPPER = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [32*NREGS-1:0]  REGS,
    input  logic                 FRAME_START,
    output logic                 CH_VALID,
    input  logic                 CH_READY,
    output logic [7:0]           CH_CODE,
    output logic [4:0]           CH_ROW,
    output logic [3:0]           CH_COL,
    output logic                 BUSY,
    output logic                 DONE
);

`ifdef REG_SCAN_LABEL_EN
    localparam int HEX0 = 3;
`else
    localparam int HEX0 = 0;
`endif

    localparam logic [3:0] LAST_COL = 4'(HEX0 + 7);
    localparam logic [4:0] LAST_ROW = 5'(NREGS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]          state;
    logic [32*NREGS-1:0] snap;
    logic [4:0]          row_q;
    logic [3:0]          col_q;
    logic [7:0]          code_q;

    logic [4:0]          row_nxt;
    logic [3:0]          col_nxt;
    logic                last_xfer;
    logic [31:0]         word_nxt;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        // 0x37 + 10 = 'A', 0x57 + 10 = 'a'
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return (UPPER ? 8'h37 : 8'h57) + {4'h0, nib};
    endfunction

    function automatic logic [7:0] char_at(input logic [31:0] word,
                                           input logic [4:0]  row,
                                           input logic [3:0]  col);
`ifdef REG_SCAN_LABEL_EN
        logic [5:0]  num;
`endif
        logic [3:0]  k;
        logic [31:0] sh;
`ifdef REG_SCAN_LABEL_EN
        // Rows are labelled with the 1-based register number.
        num = {1'b0, row} + 6'd1;
        if (col == 4'd0) return 8'h30 + {2'b00, num / 6'd10};
        if (col == 4'd1) return 8'h30 + {2'b00, num % 6'd10};
        if (col == 4'd2) return 8'h3A;
`endif
        // Hex digit k is nibble [31-4k -: 4]: most significant nibble first.
        k  = col - 4'(HEX0);
        sh = word >> (5'd28 - {k[2:0], 2'b00});
        return hex_char(sh[3:0]);
    endfunction

    always_comb begin
        col_nxt   = col_q + 4'd1;
        row_nxt   = row_q;
        if (col_q == LAST_COL) begin
            col_nxt = 4'd0;
            row_nxt = row_q + 5'd1;
        end
        last_xfer = (col_q == LAST_COL) && (row_q == LAST_ROW);
        // Out of range only on the last transfer, where the result is unused.
        word_nxt  = snap[{row_nxt, 5'b00000} +: 32];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            snap   <= '0;
            row_q  <= '0;
            col_q  <= '0;
            code_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (FRAME_START) begin
                        state  <= S_EMIT;
                        snap   <= REGS;
                        row_q  <= '0;
                        col_q  <= '0;
                        // Snapshot is loading on this same edge, so the first
                        // character comes straight from REGS to avoid a bubble.
                        code_q <= char_at(REGS[31:0], 5'd0, 4'd0);
                    end
                end
                S_EMIT: begin
                    if (CH_READY) begin
                        if (last_xfer) begin
                            state  <= S_FIN;
                            row_q  <= '0;
                            col_q  <= '0;
                            code_q <= '0;
                        end else begin
                            row_q  <= row_nxt;
                            col_q  <= col_nxt;
                            code_q <= char_at(word_nxt, row_nxt, col_nxt);
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Row/col/code are zeroed whenever EMIT is left, so they read 0 outside it.
    assign CH_VALID = (state == S_EMIT);
    assign BUSY     = (state == S_EMIT) || (state == S_FIN);
    assign DONE     = (state == S_FIN);
    assign CH_CODE  = code_q;
    assign CH_ROW   = row_q;
    assign CH_COL   = col_q;

endmodule

// File: tb/tb_reg_hex_scanner.sv
module tb_reg_hex_scanner;

    localparam int NREGS = 32;
`ifdef REG_SCAN_LABEL_EN
    localparam int COLS = 11;
    localparam int HEX0 = 3;
`else
    localparam int COLS = 8;
    localparam int HEX0 = 0;
`endif
    localparam int TOTAL = NREGS * COLS;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic [32*NREGS-1:0] REGS = '0;
    logic                FRAME_START = 1'b0;
    logic                CH_READY = 1'b0;
    logic                CH_VALID;
    logic [7:0]          CH_CODE;
    logic [4:0]          CH_ROW;
    logic [3:0]          CH_COL;
    logic                BUSY;
    logic                DONE;

    reg_hex_scanner #(.NREGS(NREGS), .UPPER(1'b1)) dut (
        .CLK(CLK), .RST(RST), .REGS(REGS), .FRAME_START(FRAME_START),
        .CH_VALID(CH_VALID), .CH_READY(CH_READY), .CH_CODE(CH_CODE),
        .CH_ROW(CH_ROW), .CH_COL(CH_COL), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Expected character stream for the current snapshot.
    logic [7:0] exp_code [TOTAL];
    logic [4:0] exp_row  [TOTAL];
    logic [3:0] exp_col  [TOTAL];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Text layout computed straight from the register values: one row per
    // register, optional "NN:" label, then the 8 hex digits MSB first.
    task automatic build_model(input logic [32*NREGS-1:0] regs);
        string hex;
        logic [31:0] w;
        int idx, num, d;
        hex = "0123456789ABCDEF";
        for (int r = 0; r < NREGS; r++) begin
            w   = regs[32*r +: 32];
            num = r + 1;
            for (int c = 0; c < COLS; c++) begin
                idx = r * COLS + c;
                exp_row[idx] = 5'(r);
                exp_col[idx] = 4'(c);
                if (c < HEX0) begin
                    if (c == 0)      exp_code[idx] = 8'(48 + num / 10);
                    else if (c == 1) exp_code[idx] = 8'(48 + num % 10);
                    else             exp_code[idx] = ":";
                end else begin
                    d = int'((w >> (4 * (7 - (c - HEX0)))) & 32'hF);
                    exp_code[idx] = hex[d];
                end
            end
        end
    endtask

    task automatic randomize_regs();
        for (int r = 0; r < NREGS; r++) REGS[32*r +: 32] = $urandom;
    endtask

    // Called #1 after a clock edge with the DUT idle.
    task automatic run_scan(input bit bp, input int snap_at, input int rst_at, input bit chk_done_cyc);
        int   idx = 0;
        int   n = 0;
        int   extra = 0;
        bit   stalled = 0;
        bit   injected = 0;
        bit   pv;
        bit   rdy;
        logic [7:0] pc;
        logic [4:0] pr;
        logic [3:0] pcl;

        FRAME_START = 1'b1;
        @(posedge CLK); #1;
        FRAME_START = 1'b0;
        check("start_valid", 32'(CH_VALID), 32'd1);

        while (n < 4000) begin
            if (DONE) break;
            check("emit_valid", 32'(CH_VALID), 32'd1);
            check("emit_busy", 32'(BUSY), 32'd1);
            if (CH_VALID) begin
                if (stalled) begin
                    check("stall_code", 32'(CH_CODE), 32'(pc));
                    check("stall_row",  32'(CH_ROW),  32'(pr));
                    check("stall_col",  32'(CH_COL),  32'(pcl));
                end
                if (idx < TOTAL) begin
                    check("code", 32'(CH_CODE), 32'(exp_code[idx]));
                    check("row",  32'(CH_ROW),  32'(exp_row[idx]));
                    check("col",  32'(CH_COL),  32'(exp_col[idx]));
                end else begin
                    check("overrun", 32'(idx), 32'(TOTAL - 1));
                end
            end

            if (rst_at >= 0 && idx == rst_at) begin
                RST = 1'b0;
                #1;
                check("rst_valid", 32'(CH_VALID), 32'd0);
                check("rst_busy",  32'(BUSY), 32'd0);
                check("rst_code",  32'(CH_CODE), 32'd0);
                check("rst_row",   32'(CH_ROW), 32'd0);
                check("rst_col",   32'(CH_COL), 32'd0);
                FRAME_START = 1'b1;
                CH_READY = 1'b1;
                repeat (3) @(posedge CLK);
                #1;
                check("rst_hold_valid", 32'(CH_VALID), 32'd0);
                FRAME_START = 1'b0;
                RST = 1'b1;
                for (int i = 0; i < 12; i++) begin
                    @(posedge CLK); #1;
                    if (DONE || CH_VALID || BUSY) extra++;
                end
                check("rst_no_done", 32'(extra), 32'd0);
                return;
            end

            if (snap_at >= 0 && idx == snap_at && !injected) begin
                REGS = '1;
                FRAME_START = 1'b1;
                injected = 1'b1;
            end else begin
                FRAME_START = 1'b0;
            end

            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            CH_READY = rdy;
            pv = CH_VALID; pc = CH_CODE; pr = CH_ROW; pcl = CH_COL;
            stalled = CH_VALID && !rdy;
            @(posedge CLK); #1;
            n++;
            if (pv && rdy) idx++;
        end
        FRAME_START = 1'b0;

        check("no_timeout", 32'(n < 4000), 32'd1);
        check("transfers", 32'(idx), 32'(TOTAL));
        // n counts edges after the start edge; the DONE cycle is cycle n+1.
        if (chk_done_cyc) check("done_cycle", 32'(n + 1), 32'(TOTAL + 1));
        check("fin_valid", 32'(CH_VALID), 32'd0);
        check("fin_busy", 32'(BUSY), 32'd1);

        // A request sampled at the end of FIN must be dropped.
        FRAME_START = 1'b1;
        @(posedge CLK); #1;
        FRAME_START = 1'b0;
        check("fin_drop_valid", 32'(CH_VALID), 32'd0);
        check("fin_drop_busy", 32'(BUSY), 32'd0);
        check("done_one_cycle", 32'(DONE), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (CH_VALID || DONE || BUSY) extra++;
        end
        check("no_second_scan", 32'(extra), 32'd0);
    endtask

    initial begin
        // Reset held with a pending request: everything stays quiet.
        RST = 1'b0;
        FRAME_START = 1'b1;
        CH_READY = 1'b1;
        randomize_regs();
        repeat (4) @(posedge CLK);
        #1;
        check("reset_valid", 32'(CH_VALID), 32'd0);
        check("reset_busy",  32'(BUSY), 32'd0);
        check("reset_done",  32'(DONE), 32'd0);
        check("reset_code",  32'(CH_CODE), 32'd0);
        check("reset_row",   32'(CH_ROW), 32'd0);
        check("reset_col",   32'(CH_COL), 32'd0);
        FRAME_START = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("idle_valid", 32'(CH_VALID), 32'd0);

        // Basic scan with the two anchor registers.
        randomize_regs();
        REGS[31:0]     = 32'h0000_00A5;
        REGS[1023:992] = 32'hDEAD_BEEF;
        build_model(REGS);
        run_scan(1'b0, -1, -1, 1'b1);

        // Same registers under random backpressure.
        run_scan(1'b1, -1, -1, 1'b0);

        // Registers overwritten plus a stray request mid-scan.
        randomize_regs();
        build_model(REGS);
        run_scan(1'b0, 50, -1, 1'b1);

        // Reset in the middle of a scan.
        randomize_regs();
        build_model(REGS);
        run_scan(1'b0, -1, 100, 1'b0);

        // Fresh scan after the abort restarts from row 0, col 0.
        randomize_regs();
        build_model(REGS);
        run_scan(1'b1, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
